// File: rtl/ysyx_23060025_axi_wr_master.sv
// AXI-lite style write initiator: one store in flight, AW and W issued together,
// the B response (or a forced timeout error) is reported as a single done pulse.
module ysyx_23060025_axi_wr_master #(
  parameter int DATA_LEN = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [DATA_LEN-1:0]   req_addr_i,
  input  logic [DATA_LEN-1:0]   req_data_i,
  input  logic [DATA_LEN/8-1:0] req_strb_i,
  output logic [DATA_LEN-1:0]   addr_w_addr_o,
  output logic                  addr_w_valid_o,
  input  logic                  addr_w_ready_i,
  output logic [DATA_LEN-1:0]   w_data_o,
  output logic [DATA_LEN/8-1:0] w_strb_o,
  output logic                  w_valid_o,
  input  logic                  w_ready_i,
  input  logic [1:0]            bkwd_resp_i,
  input  logic                  bkwd_valid_i,
  output logic                  bkwd_ready_o,
  output logic                  done_o,
  output logic [1:0]            resp_o,
  output logic                  timeout_o
);

  localparam int STRB_W = DATA_LEN / 8;
  // A zero TIMEOUT still gets a 1-bit counter so the declarations stay legal.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};
  localparam bit TO_EN = (TIMEOUT > 0);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SEND      = 2'd1;
  localparam logic [1:0] WAIT_RESP = 2'd2;

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [1:0]          state_q,    state_d;
  logic                aw_valid_q, aw_valid_d;
  logic                w_valid_q,  w_valid_d;
  logic                aw_done_q,  aw_done_d;
  logic                w_done_q,   w_done_d;
  logic [DATA_LEN-1:0] addr_q,     addr_d;
  logic [DATA_LEN-1:0] data_q,     data_d;
  logic [STRB_W-1:0]   strb_q,     strb_d;
  logic [1:0]          resp_q,     resp_d;
  logic                done_q,     done_d;
  logic                timeout_q,  timeout_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic                aw_hs;
  logic                w_hs;

  // Next-state and next-output computation for the single outstanding store.
  always_comb begin
    state_d    = state_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    addr_d     = addr_q;
    data_d     = data_q;
    strb_d     = strb_q;
    resp_d     = resp_q;
    done_d     = 1'b0;
    timeout_d  = timeout_q;
    cnt_d      = cnt_q;
    aw_hs      = aw_valid_q & addr_w_ready_i;
    w_hs       = w_valid_q & w_ready_i;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d     = req_addr_i;
          data_d     = req_data_i;
          strb_d     = req_strb_i;
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          state_d    = SEND;
        end else begin
          state_d = IDLE;
        end
      end

      SEND: begin
        if (aw_hs) begin
          aw_valid_d = 1'b0;
          aw_done_d  = 1'b1;
        end else begin
          aw_valid_d = aw_valid_q;
        end
        if (w_hs) begin
          w_valid_d = 1'b0;
          w_done_d  = 1'b1;
        end else begin
          w_valid_d = w_valid_q;
        end
        // A channel counts as done either from its flag or from this cycle's handshake.
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
          state_d = WAIT_RESP;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = SEND;
        end
      end

      WAIT_RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bkwd_valid_i) begin
          resp_d    = bkwd_resp_i;
          timeout_d = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          resp_d    = RESP_SLVERR;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = WAIT_RESP;
        end
      end

      default: begin
        state_d    = IDLE;
        aw_valid_d = 1'b0;
        w_valid_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      addr_q     <= {DATA_LEN{1'b0}};
      data_q     <= {DATA_LEN{1'b0}};
      strb_q     <= {STRB_W{1'b0}};
      resp_q     <= 2'b00;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      strb_q     <= strb_d;
      resp_q     <= resp_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
    end
  end

  assign req_ready_o    = (state_q == IDLE);
  assign bkwd_ready_o   = (state_q == WAIT_RESP);
  assign addr_w_addr_o  = addr_q;
  assign addr_w_valid_o = aw_valid_q;
  assign w_data_o       = data_q;
  assign w_strb_o       = strb_q;
  assign w_valid_o      = w_valid_q;
  assign done_o         = done_q;
  assign resp_o         = resp_q;
  assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_ysyx_23060025_axi_wr_master.sv
// Randomised and directed bench for the AXI-lite write master; a timestamp-based
// transaction model predicts every output each cycle.
module tb_ysyx_23060025_axi_wr_master;

  localparam int     TMO = 8;
  localparam longint INF = 64'sd1000000000;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_strb_i;
  logic [31:0] addr_w_addr_o;
  logic        addr_w_valid_o;
  logic        addr_w_ready_i;
  logic [31:0] w_data_o;
  logic [3:0]  w_strb_o;
  logic        w_valid_o;
  logic        w_ready_i;
  logic [1:0]  bkwd_resp_i;
  logic        bkwd_valid_i;
  logic        bkwd_ready_o;
  logic        done_o;
  logic [1:0]  resp_o;
  logic        timeout_o;

  always #5 clock = ~clock;

  ysyx_23060025_axi_wr_master #(.DATA_LEN(32), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_strb_i(req_strb_i),
    .addr_w_addr_o(addr_w_addr_o), .addr_w_valid_o(addr_w_valid_o), .addr_w_ready_i(addr_w_ready_i),
    .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
    .bkwd_resp_i(bkwd_resp_i), .bkwd_valid_i(bkwd_valid_i), .bkwd_ready_o(bkwd_ready_o),
    .done_o(done_o), .resp_o(resp_o), .timeout_o(timeout_o)
  );

  int checks = 0;
  int failures = 0;
  longint cyc = 0;

  // Transaction timestamps (cycle numbers); INF means "not happened yet".
  longint t_acc, t_aw, t_w, t_wr, t_done;
  logic [31:0] exp_addr, exp_data;
  logic [3:0]  exp_strb;
  logic [1:0]  exp_resp;
  logic        exp_to;

  bit          rand_mode = 1'b0;
  int          req_pend = 0;
  int          aw_dly = 0, w_dly = 0, b_dly = 0;
  bit          b_never = 1'b0, force_b = 1'b0;
  logic [1:0]  dir_resp = 2'b00;
  logic [31:0] pl_addr = 32'd0, pl_data = 32'd0;
  logic [3:0]  pl_strb = 4'd0;

  int          done_cnt = 0, aw_cnt = 0, w_cnt = 0, acc_cnt = 0;
  longint      last_done_cyc = 0, last_acc_cyc = 0;
  logic [1:0]  obs_resp = 2'b00;
  logic        obs_to = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", name, cyc, act, exp_v);
    end
  endtask

  task automatic model_reset();
    t_acc = INF; t_aw = INF; t_w = INF; t_wr = INF; t_done = INF;
    exp_addr = 32'd0; exp_data = 32'd0; exp_strb = 4'd0;
    exp_resp = 2'b00; exp_to = 1'b0;
  endtask

  function automatic bit model_busy();
    return (t_acc < cyc) && (cyc < t_done);
  endfunction

  // One clock cycle: check outputs, choose inputs, advance the model.
  task automatic step();
    bit e_rr, e_aw, e_w, e_br, e_done;
    logic rq_v, aw_r, w_r, b_v;
    logic [1:0] b_r;
    logic [31:0] a, d;
    logic [3:0] s;
    @(negedge clock);
    cyc++;
    e_rr   = !model_busy();
    e_aw   = (t_acc < cyc) && (cyc <= t_aw);
    e_w    = (t_acc < cyc) && (cyc <= t_w);
    e_br   = (t_wr <= cyc) && (cyc < t_done);
    e_done = (cyc == t_done);
    chk("req_ready", 32'(req_ready_o), 32'(e_rr));
    chk("aw_valid", 32'(addr_w_valid_o), 32'(e_aw));
    chk("w_valid", 32'(w_valid_o), 32'(e_w));
    chk("bkwd_ready", 32'(bkwd_ready_o), 32'(e_br));
    chk("done", 32'(done_o), 32'(e_done));
    chk("aw_addr", addr_w_addr_o, exp_addr);
    chk("w_data", w_data_o, exp_data);
    chk("w_strb", 32'(w_strb_o), 32'(exp_strb));
    if (e_done) begin
      chk("resp", 32'(resp_o), 32'(exp_resp));
      chk("timeout", 32'(timeout_o), 32'(exp_to));
    end
    if (done_o === 1'b1) begin
      done_cnt++; last_done_cyc = cyc; obs_resp = resp_o; obs_to = timeout_o;
    end
    if (addr_w_valid_o === 1'b1) aw_cnt++;
    if (w_valid_o === 1'b1) w_cnt++;

    if (rand_mode) begin
      rq_v = ($urandom_range(0, 2) == 0);
      a = $urandom; d = $urandom; s = 4'($urandom);
      aw_r = ($urandom_range(0, 2) != 0);
      w_r  = ($urandom_range(0, 2) != 0);
      b_v  = ($urandom_range(0, 3) == 0);
      b_r  = 2'($urandom);
    end else begin
      rq_v = (req_pend > 0);
      a = pl_addr; d = pl_data; s = pl_strb;
      aw_r = e_aw && ((cyc - (t_acc + 1)) >= aw_dly);
      w_r  = e_w && ((cyc - (t_acc + 1)) >= w_dly);
      b_v  = force_b || (!b_never && e_br && ((cyc - t_wr) >= b_dly));
      b_r  = dir_resp;
    end
    req_valid_i = rq_v; req_addr_i = a; req_data_i = d; req_strb_i = s;
    addr_w_ready_i = aw_r; w_ready_i = w_r;
    bkwd_valid_i = b_v; bkwd_resp_i = b_r;

    if (e_rr && rq_v) begin
      t_acc = cyc; t_aw = INF; t_w = INF; t_wr = INF; t_done = INF;
      exp_addr = a; exp_data = d; exp_strb = s;
      aw_cnt = 0; w_cnt = 0; acc_cnt++; last_acc_cyc = cyc;
      if (!rand_mode) begin
        req_pend--;
        pl_addr = $urandom; pl_data = $urandom; pl_strb = 4'($urandom);
      end
    end
    if (e_aw && aw_r) t_aw = cyc;
    if (e_w && w_r) t_w = cyc;
    if ((t_aw != INF) && (t_w != INF) && (t_wr == INF))
      t_wr = ((t_aw > t_w) ? t_aw : t_w) + 1;
    if (e_br && b_v) begin
      t_done = cyc + 1; exp_resp = b_r; exp_to = 1'b0;
    end else if (e_br && (cyc == t_wr + TMO - 1)) begin
      t_done = cyc + 1; exp_resp = 2'b10; exp_to = 1'b1;
    end
  endtask

  task automatic run_txn(input string name, input int budget);
    int n0;
    int k;
    n0 = done_cnt; k = 0;
    req_pend = 1;
    while ((done_cnt == n0) && (k < budget)) begin
      step(); k++;
    end
    req_pend = 0;
    chk({name, "_completes"}, 32'(done_cnt - n0), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int k;
    reset = 1'b1;
    req_valid_i = 1'b0; req_addr_i = 32'd0; req_data_i = 32'd0; req_strb_i = 4'd0;
    addr_w_ready_i = 1'b0; w_ready_i = 1'b0; bkwd_valid_i = 1'b0; bkwd_resp_i = 2'b00;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("rst_aw_valid", 32'(addr_w_valid_o), 32'd0);
    chk("rst_w_valid", 32'(w_valid_o), 32'd0);
    chk("rst_bkwd_ready", 32'(bkwd_ready_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_resp", 32'(resp_o), 32'd0);
    chk("rst_addr", addr_w_addr_o, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Zero-wait slave
    pl_addr = 32'hA000_03F8; pl_data = 32'h0000_0041; pl_strb = 4'b0001;
    aw_dly = 0; w_dly = 0; b_dly = 0; dir_resp = 2'b00;
    run_txn("zero_wait", 40);
    chk("zw_latency", 32'(last_done_cyc - last_acc_cyc), 32'd3);
    chk("zw_aw_cycles", 32'(aw_cnt), 32'd1);
    chk("zw_w_cycles", 32'(w_cnt), 32'd1);
    chk("zw_resp", 32'(obs_resp), 32'd0);
    chk("zw_timeout", 32'(obs_to), 32'd0);
    chk("zw_addr_hold", addr_w_addr_o, 32'hA000_03F8);

    // Skewed readies
    pl_data = 32'h1234_5678; aw_dly = 2; w_dly = 5;
    run_txn("skewed", 40);
    chk("sk_latency", 32'(last_done_cyc - last_acc_cyc), 32'd8);
    chk("sk_aw_cycles", 32'(aw_cnt), 32'd3);
    chk("sk_w_cycles", 32'(w_cnt), 32'd6);
    chk("sk_w_data", w_data_o, 32'h1234_5678);

    // W before AW
    aw_dly = 3; w_dly = 0;
    n0 = done_cnt;
    run_txn("w_first", 40);
    repeat (3) step();
    chk("wf_done_once", 32'(done_cnt - n0), 32'd1);
    chk("wf_latency", 32'(last_done_cyc - last_acc_cyc), 32'd6);
    chk("wf_aw_cycles", 32'(aw_cnt), 32'd4);

    // Error response
    aw_dly = 0; dir_resp = 2'b11;
    run_txn("decerr", 40);
    chk("er_resp", 32'(obs_resp), 32'd3);
    chk("er_timeout", 32'(obs_to), 32'd0);

    // Timeout, then a late B that must be ignored
    b_never = 1'b1;
    run_txn("timeout", 40);
    chk("to_latency", 32'(last_done_cyc - last_acc_cyc), 32'd10);
    chk("to_resp", 32'(obs_resp), 32'd2);
    chk("to_flag", 32'(obs_to), 32'd1);
    b_never = 1'b0;
    n0 = done_cnt;
    force_b = 1'b1; step(); force_b = 1'b0;
    repeat (2) step();
    chk("late_b_ignored", 32'(done_cnt - n0), 32'd0);

    // B arriving on the last counted cycle beats the timeout
    b_dly = 7; dir_resp = 2'b11;
    run_txn("b_at_limit", 40);
    chk("bl_latency", 32'(last_done_cyc - last_acc_cyc), 32'd10);
    chk("bl_resp", 32'(obs_resp), 32'd3);
    chk("bl_timeout", 32'(obs_to), 32'd0);
    b_dly = 0; dir_resp = 2'b00;

    // Reset while AW is pending
    aw_dly = 100; w_dly = 0; req_pend = 1;
    k = 0;
    while ((req_pend > 0) && (k < 10)) begin step(); k++; end
    repeat (3) step();
    n0 = done_cnt;
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_aw_valid", 32'(addr_w_valid_o), 32'd0);
    chk("mid_rst_w_valid", 32'(w_valid_o), 32'd0);
    chk("mid_rst_done", 32'(done_o), 32'd0);
    req_valid_i = 1'b0; addr_w_ready_i = 1'b0; w_ready_i = 1'b0; bkwd_valid_i = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    chk("mid_rst_no_done", 32'(done_cnt - n0), 32'd0);

    // Back-to-back after reset
    aw_dly = 0; req_pend = 2;
    n0 = done_cnt; k = 0;
    while ((done_cnt == n0) && (k < 40)) begin step(); k++; end
    chk("b2b_first_done", 32'(done_cnt - n0), 32'd1);
    chk("b2b_accept_on_done", 32'(last_acc_cyc - last_done_cyc), 32'd0);
    k = 0;
    while ((done_cnt == n0 + 1) && (k < 40)) begin step(); k++; end
    chk("b2b_second_done", 32'(done_cnt - n0), 32'd2);
    chk("b2b_latency", 32'(last_done_cyc - last_acc_cyc), 32'd3);
    req_pend = 0;

    // Randomised traffic
    rand_mode = 1'b1;
    repeat (800) step();
    rand_mode = 1'b0; req_pend = 0; b_dly = 0; aw_dly = 0; w_dly = 0;
    k = 0;
    while (model_busy() && (k < 40)) begin step(); k++; end
    step();
    chk("drain_idle", 32'(req_ready_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_23060025_axi_wr_master.md
# ysyx_23060025_axi_wr_master

AXI-lite style write initiator that converts single store requests from the LSU into address-write, write-data and write-response channel transactions toward memory-mapped slaves (UART, SRAM, CLINT). It is the master-side counterpart of the slave write channel used by the core's peripherals. It holds one outstanding transaction at a time, returns the slave response to the requester, and enforces an optional response timeout.

## Interface
- DATA_LEN, 32, address and data width
- TIMEOUT, 255, cycles to wait in WAIT_RESP before forcing an error completion; 0 disables the timeout

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid_i  in  1  requester has a store pending
- req_ready_o  out  1  block can accept a store
- req_addr_i  in  DATA_LEN  store address
- req_data_i  in  DATA_LEN  store data
- req_strb_i  in  DATA_LEN/8  byte strobes
- addr_w_addr_o  out  DATA_LEN  AW address
- addr_w_valid_o  out  1  AW valid
- addr_w_ready_i  in  1  AW ready from slave
- w_data_o  out  DATA_LEN  W data
- w_strb_o  out  DATA_LEN/8  W strobes
- w_valid_o  out  1  W valid
- w_ready_i  in  1  W ready from slave
- bkwd_resp_i  in  2  B response (00 OKAY, 10 SLVERR, 11 DECERR)
- bkwd_valid_i  in  1  B valid from slave
- bkwd_ready_o  out  1  master ready for B
- done_o  out  1  one-cycle completion pulse
- resp_o  out  2  response of the completed store, valid with done_o
- timeout_o  out  1  completion was forced by timeout, valid with done_o

## Operation
- States: IDLE, SEND, WAIT_RESP.
- IDLE
  - req_ready_o=1.
  - On req_valid_i & req_ready_o: latch the address, data and strobes into output registers.
  - Set addr_w_valid_o=1 and w_valid_o=1 on the next edge, clear aw_done/w_done, go to SEND.
- SEND
  - AW handshake = addr_w_valid_o & addr_w_ready_i. On it, clear addr_w_valid_o next edge and set aw_done.
  - W handshake = w_valid_o & w_ready_i. Same for w_valid_o and w_done.
  - The two handshakes are independent: either order, or the same cycle.
  - Once a valid is asserted it stays asserted, with stable payload, until its handshake.
  - When both channels are done (flags or this cycle's handshakes), go to WAIT_RESP.
- WAIT_RESP
  - bkwd_ready_o=1; the timeout counter increments each cycle.
  - On bkwd_valid_i: capture bkwd_resp_i into resp_o, pulse done_o, timeout_o=0, go to IDLE.
  - If TIMEOUT≠0 and counter==TIMEOUT-1 with no bkwd_valid_i: resp_o=2'b10, timeout_o=1, pulse done_o, go to IDLE.
  - If bkwd_valid_i arrives in that same cycle, the real response wins.
- A late B after a timeout is not accepted, because bkwd_ready_o=0 outside WAIT_RESP.
- Payload outputs hold their last value in IDLE.

## Timing
- Reset (async assert; release synchronous to clock):
  - State IDLE, req_ready_o=1.
  - addr_w_valid_o, w_valid_o, bkwd_ready_o, done_o, timeout_o = 0.
  - resp_o=0, addr/data/strb outputs=0, counter=0.
- Reset asserted mid-transaction aborts immediately: valids drop asynchronously and no done_o is produced.
- All outputs are registered except req_ready_o and bkwd_ready_o, which decode from state only. No combinational path from any input to any output.
- Request accepted at edge E0 → AW/W valid in cycle E0+1.
- With slave readies high, both handshakes complete in E0+1, and WAIT_RESP starts at E0+2.
- B handshake in cycle E0+2 → done_o high in cycle E0+3 (minimum latency 3 cycles).
- done_o asserts in the cycle state is back in IDLE, so req_ready_o=1 that cycle and a new request is accepted back-to-back.
- The counter is $clog2(TIMEOUT+1) bits wide and is cleared on entry to WAIT_RESP.

## Test plan
- Zero-wait slave:
  - Stimulus: req addr 0xA000_03F8, data 0x41, strb 4'b0001; addr_w_ready_i=w_ready_i=1; slave returns B OKAY one cycle after the handshake.
  - Required: done_o in the 3rd cycle after acceptance, resp_o=00, timeout_o=0; AW/W valid for exactly 1 cycle.
- Skewed readies:
  - Stimulus: addr_w_ready_i asserted 2 cycles after valid, w_ready_i after 5.
  - Required: addr_w_valid_o drops after its handshake; w_valid_o holds 0x1234_5678 stable until its handshake; WAIT_RESP entered only after the W handshake.
- W before AW:
  - Stimulus: w_ready_i=1 immediately, addr_w_ready_i after 3 cycles.
  - Required: single transaction, and done_o exactly once.
- Error response:
  - Stimulus: slave returns bkwd_resp_i=2'b11.
  - Required: done_o with resp_o=11, timeout_o=0.
- Timeout:
  - Stimulus: TIMEOUT=8; slave never asserts bkwd_valid_i.
  - Required: done_o 8 cycles after WAIT_RESP entry with resp_o=10, timeout_o=1. A B pulse driven afterwards is ignored (bkwd_ready_o=0).
- Reset mid-SEND, then back-to-back:
  - Stimulus: assert reset while AW is pending, then issue two back-to-back requests.
  - Required: valids clear within the reset cycle with no done_o; after release the 2nd request is accepted in the same cycle as the 1st done_o.
